// File: rtl/ps2_codes_pkg.sv
// Shared PS/2 scan-code set 2 constants, decoder state encoding and key helpers.
package ps2_codes_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HELD_W = 3;

  localparam logic [BYTE_W-1:0] PS2_BREAK  = 8'hF0;
  localparam logic [BYTE_W-1:0] PS2_EXT    = 8'hE0;
  localparam logic [BYTE_W-1:0] PS2_PAUSE  = 8'hE1;
  localparam logic [BYTE_W-1:0] PS2_BAT_OK = 8'hAA;
  localparam logic [BYTE_W-1:0] PS2_ACK    = 8'hFA;
  localparam logic [BYTE_W-1:0] PS2_RESEND = 8'hFE;
  localparam logic [BYTE_W-1:0] PS2_OVR0   = 8'h00;
  localparam logic [BYTE_W-1:0] PS2_OVR1   = 8'hFF;

  localparam logic [BYTE_W-1:0] KEY_HIT    = 8'h33;
  localparam logic [BYTE_W-1:0] KEY_STAND  = 8'h1B;
  localparam logic [BYTE_W-1:0] KEY_DEAL   = 8'h23;

  localparam int unsigned HELD_HIT   = 0;
  localparam int unsigned HELD_STAND = 1;
  localparam int unsigned HELD_DEAL  = 2;

  typedef logic [HELD_W-1:0] key_vec_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BREAK     = 3'd1,
    S_EXT       = 3'd2,
    S_EXT_BREAK = 3'd3,
    S_PAUSE     = 3'd4
  } state_t;

  // One-hot position of a mapped key in the held vector, zero for anything else.
  function automatic key_vec_t key_mask(input logic [BYTE_W-1:0] code);
    key_vec_t m;
    m = '0;
    case (code)
      KEY_HIT:   m[HELD_HIT]   = 1'b1;
      KEY_STAND: m[HELD_STAND] = 1'b1;
      KEY_DEAL:  m[HELD_DEAL]  = 1'b1;
      default:   m = '0;
    endcase
    return m;
  endfunction

  function automatic logic is_prefix(input logic [BYTE_W-1:0] code);
    return (code == PS2_BREAK) || (code == PS2_EXT) || (code == PS2_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_seq_timer.sv
// Stall timer for multi-byte PS/2 sequences; expires on the edge the count reaches CYCLES-1.
module ps2_seq_timer #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_QUIET = CNT_W'(CYCLES - 2);

  logic [CNT_W-1:0] r_count;

  // Expiry ignores i_clr so a strobe landing on the final edge still loses to the timeout.
  assign o_expire_c = i_en && (r_count == LAST_QUIET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_en || i_clr || o_expire_c) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code set 2 decoder producing first-make hit/stand/deal pulses for the blackjack FSM.
module ps2_key_decoder
  import ps2_codes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned PAUSE_TAIL     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BYTE_W-1:0] received_data,
  input  logic             received_data_en,
  output logic             hit_pressed,
  output logic             stand_pressed,
  output logic             deal_pressed,
  output logic [HELD_W-1:0] key_held,
  output logic [BYTE_W-1:0] last_code,
  output logic             seq_timeout
);

  localparam int unsigned SKIP_W = (PAUSE_TAIL > 0) ? $clog2(PAUSE_TAIL + 1) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  state_t            w_eff_state;
  logic              w_busy;
  logic              w_expire;

  logic [SKIP_W-1:0] r_skip;
  logic [SKIP_W-1:0] w_skip_nxt;
  key_vec_t          r_held;
  key_vec_t          w_held_nxt;
  key_vec_t          r_pulse;
  key_vec_t          w_pulse_nxt;
  key_vec_t          w_mask;
  logic [BYTE_W-1:0] r_last;
  logic [BYTE_W-1:0] w_last_nxt;
  logic              r_timeout;

  assign w_busy = (r_state != S_IDLE);

  ps2_seq_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_busy),
    .i_clr      (received_data_en),
    .o_expire_c (w_expire)
  );

  // An abandoned sequence means the current byte is seen from S_IDLE.
  always_comb begin
    w_eff_state = r_state;
    if (w_expire) begin
      w_eff_state = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_eff_state;
    if (received_data_en) begin
      case (w_eff_state)
        S_IDLE: begin
          if (received_data == PS2_BREAK) begin
            w_state_nxt = S_BREAK;
          end else if (received_data == PS2_EXT) begin
            w_state_nxt = S_EXT;
          end else if (received_data == PS2_PAUSE) begin
            w_state_nxt = S_PAUSE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_BREAK:     w_state_nxt = S_IDLE;
        S_EXT:       w_state_nxt = (received_data == PS2_BREAK) ? S_EXT_BREAK : S_IDLE;
        S_EXT_BREAK: w_state_nxt = S_IDLE;
        S_PAUSE: begin
          if (r_skip <= SKIP_W'(1)) begin
            w_state_nxt = S_IDLE;
          end
        end
        default:     w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_pulse_nxt = '0;
    w_held_nxt  = r_held;
    w_last_nxt  = r_last;
    w_skip_nxt  = r_skip;
    w_mask      = key_mask(received_data);
    if (received_data_en) begin
      if ((w_eff_state != S_PAUSE) && !is_prefix(received_data)) begin
        w_last_nxt = received_data;
      end
      case (w_eff_state)
        S_IDLE: begin
          if (received_data == PS2_PAUSE) begin
            w_skip_nxt = SKIP_W'(PAUSE_TAIL);
          end else if ((received_data == PS2_OVR0) || (received_data == PS2_OVR1)) begin
            w_held_nxt = '0;
          end else if ((w_mask != '0) && ((w_mask & r_held) == '0)) begin
            w_held_nxt  = r_held | w_mask;
            w_pulse_nxt = w_mask;
          end
        end
        S_BREAK: w_held_nxt = r_held & ~w_mask;
        S_PAUSE: w_skip_nxt = r_skip - SKIP_W'(1);
        default: w_held_nxt = r_held;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip    <= '0;
      r_held    <= '0;
      r_pulse   <= '0;
      r_last    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_skip    <= w_skip_nxt;
      r_held    <= w_held_nxt;
      r_pulse   <= w_pulse_nxt;
      r_last    <= w_last_nxt;
      r_timeout <= w_expire;
    end
  end

  assign hit_pressed   = r_pulse[HELD_HIT];
  assign stand_pressed = r_pulse[HELD_STAND];
  assign deal_pressed  = r_pulse[HELD_DEAL];
  assign key_held      = r_held;
  assign last_code     = r_last;
  assign seq_timeout   = r_timeout;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench: directed test-plan sequences plus random byte streams against a sequence-level model.
module tb_ps2_key_decoder;

  localparam int unsigned TO_CYC = 16;
  localparam int unsigned TAIL   = 7;

  logic       clk;
  logic       rst_n;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       hit_pressed;
  logic       stand_pressed;
  logic       deal_pressed;
  logic [2:0] key_held;
  logic [7:0] last_code;
  logic       seq_timeout;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES (TO_CYC),
    .PAUSE_TAIL     (TAIL)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .hit_pressed      (hit_pressed),
    .stand_pressed    (stand_pressed),
    .deal_pressed     (deal_pressed),
    .key_held         (key_held),
    .last_code        (last_code),
    .seq_timeout      (seq_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_err;
  int n_chk;
  int n_hit_seen;
  int n_stand_seen;
  int n_to_seen;

  // Model: the unfinished sequence is kept as the bytes received so far.
  logic [7:0] seq_q[$];
  int         pause_left;
  int         quiet;
  logic [2:0] m_held;
  logic [7:0] m_last;
  logic [2:0] m_pulse;
  logic       m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    seq_q.delete();
    pause_left = 0;
    quiet      = 0;
    m_held     = 3'b000;
    m_last     = 8'h00;
    m_pulse    = 3'b000;
    m_to       = 1'b0;
  endtask

  function automatic int key_idx(input logic [7:0] d);
    if (d == 8'h33) return 0;
    if (d == 8'h1B) return 1;
    if (d == 8'h23) return 2;
    return -1;
  endfunction

  task automatic model_edge(input bit en, input logic [7:0] d);
    bit pending;
    bit fire;
    int idx;
    m_pulse = 3'b000;
    m_to    = 1'b0;
    pending = (seq_q.size() != 0) || (pause_left > 0);
    fire    = pending && (quiet + 1 == int'(TO_CYC) - 1);
    if (fire) begin
      seq_q.delete();
      pause_left = 0;
      quiet      = 0;
      m_to       = 1'b1;
    end
    if (en) begin
      quiet = 0;
      if (pause_left > 0) begin
        pause_left--;
      end else begin
        idx = key_idx(d);
        if (!(d == 8'hF0 || d == 8'hE0 || d == 8'hE1)) m_last = d;
        if (seq_q.size() == 0) begin
          if (d == 8'hF0 || d == 8'hE0) seq_q.push_back(d);
          else if (d == 8'hE1) pause_left = TAIL;
          else if (d == 8'h00 || d == 8'hFF) m_held = 3'b000;
          else if (idx >= 0 && !m_held[idx]) begin
            m_held[idx]  = 1'b1;
            m_pulse[idx] = 1'b1;
          end
        end else if (seq_q[0] == 8'hF0) begin
          if (idx >= 0) m_held[idx] = 1'b0;
          seq_q.delete();
        end else if (seq_q.size() == 1 && d == 8'hF0) begin
          seq_q.push_back(d);
        end else begin
          seq_q.delete();
        end
      end
    end else if (pending && !fire) begin
      quiet++;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".pulse"}, 32'({deal_pressed, stand_pressed, hit_pressed}), 32'(m_pulse));
    chk({tag, ".held"}, 32'(key_held), 32'(m_held));
    chk({tag, ".last"}, 32'(last_code), 32'(m_last));
    chk({tag, ".timeout"}, 32'(seq_timeout), 32'(m_to));
  endtask

  // One clock: present (en, d) for the next rising edge, then check all outputs.
  task automatic step(input bit en, input logic [7:0] d, input string tag);
    @(negedge clk);
    received_data_en = en;
    received_data    = d;
    @(posedge clk);
    #1;
    received_data_en = 1'b0;
    model_edge(en, d);
    n_hit_seen   += int'(hit_pressed);
    n_stand_seen += int'(stand_pressed);
    n_to_seen    += int'(seq_timeout);
    compare_all(tag);
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    step(1'b1, d, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, tag);
  endtask

  logic [7:0] pool [12];
  logic [7:0] pause_seq [8];

  initial begin
    n_err = 0; n_chk = 0;
    n_hit_seen = 0; n_stand_seen = 0; n_to_seen = 0;
    rst_n = 1'b0;
    received_data = 8'h00;
    received_data_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, "post_reset");

    // Single first make of H.
    send(8'h33, "h_make");
    chk("h_make_pulse", 32'(hit_pressed), 32'd1);
    chk("h_make_held", 32'(key_held), 32'b001);
    idle(1, "h_after");
    chk("h_pulse_one_cycle", 32'(hit_pressed), 32'd0);

    // Typematic repeats, break, new make: exactly two hit pulses in total.
    send(8'hF0, "h_brk0"); send(8'h33, "h_brk1");
    n_hit_seen = 0;
    send(8'h33, "typ0"); send(8'h33, "typ1"); send(8'h33, "typ2");
    chk("typ_held", 32'(key_held), 32'b001);
    send(8'hF0, "typ_brk0"); send(8'h33, "typ_brk1");
    chk("typ_released", 32'(key_held), 32'b000);
    send(8'h33, "typ_remake");
    chk("typ_hit_count", 32'(n_hit_seen), 32'd2);
    chk("typ_held_again", 32'(key_held), 32'b001);
    send(8'hF0, "clr0"); send(8'h33, "clr1");

    // Extended codes never pulse, even when numerically equal to S.
    n_stand_seen = 0;
    send(8'hE0, "ext0"); send(8'h1B, "ext1");
    send(8'hE0, "extb0"); send(8'hF0, "extb1"); send(8'h1B, "extb2");
    chk("ext_no_stand", 32'(n_stand_seen), 32'd0);
    chk("ext_held", 32'(key_held), 32'b000);

    // Deal then stand held together; overrun clears.
    send(8'h23, "ds0"); send(8'h1B, "ds1");
    chk("ds_held", 32'(key_held), 32'b110);
    send(8'hFF, "ovr");
    chk("ovr_held", 32'(key_held), 32'b000);

    // Stalled break: timeout on the 15th edge after F0, then 1B is a fresh make.
    n_to_seen = 0;
    send(8'hF0, "to_f0");
    idle(14, "to_wait");
    chk("to_not_yet", 32'(n_to_seen), 32'd0);
    idle(1, "to_fire");
    chk("to_fired", 32'(seq_timeout), 32'd1);
    idle(1, "to_after");
    chk("to_one_cycle", 32'(seq_timeout), 32'd0);
    send(8'h1B, "to_make");
    chk("to_stand", 32'(stand_pressed), 32'd1);

    // Strobe on the expiring edge is treated as received in S_IDLE.
    send(8'hF0, "co_f0");
    idle(14, "co_wait");
    send(8'h23, "co_make");
    chk("co_timeout", 32'(seq_timeout), 32'd1);
    chk("co_deal", 32'(deal_pressed), 32'd1);
    send(8'hFF, "co_clr");

    // Pause sequence tail is not interpreted.
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    n_hit_seen = 0; n_stand_seen = 0;
    foreach (pause_seq[i]) send(pause_seq[i], "pause");
    chk("pause_no_pulse", 32'(n_hit_seen + n_stand_seen), 32'd0);
    send(8'h33, "pause_hit");
    chk("pause_hit", 32'(hit_pressed), 32'd1);
    send(8'hFF, "pause_clr");

    // Reset in the middle of a break sequence.
    send(8'hF0, "rst_f0");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("in_reset");
    repeat (2) @(posedge clk);
    #1;
    compare_all("in_reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h23, "rst_deal");
    chk("rst_deal", 32'(deal_pressed), 32'd1);

    // Random byte streams with occasional long stalls.
    pool = '{8'h33, 8'h1B, 8'h23, 8'hF0, 8'hF0, 8'hE0, 8'hE1, 8'h00, 8'hFF, 8'hAA, 8'h14, 8'h77};
    for (int k = 0; k < 600; k++) begin
      int gap;
      gap = ($urandom_range(0, 24) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 2));
      idle(gap, "rnd_gap");
      send(pool[$urandom_range(0, 11)], "rnd");
    end
    idle(20, "drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
